// File: rtl/sprite_collision_unit.sv
// sprite_collision_unit: per-pixel dino/obstacle overlap detection.
// Accumulates per-frame hit results, publishes them at the first cycle of
// vertical blank, and exposes them over a small Avalon-MM register file.
//
// State    | Meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | disabled; accumulators held at 0
// S_SYNC   | enabled, waiting out the partial frame in progress
// S_ACTIVE | accumulating overlaps; frame end publishes the results
module sprite_collision_unit #(
    parameter int N_OBST  = 4,
    parameter int VACTIVE = 480,
    parameter int HACTIVE = 1280
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [10:0]       hcount,
    input  logic [9:0]        vcount,
    input  logic              blank_n,
    input  logic              dino_opaque,
    input  logic [N_OBST-1:0] obst_opaque,
    input  logic              chipselect,
    input  logic              read,
    input  logic              write,
    input  logic [2:0]        address,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              irq
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SYNC   = 2'd1,
        S_ACTIVE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [10:0]       hc_q;
    logic [9:0]        vc_q;
    logic              blank_q;
    logic              dino_q;
    logic [N_OBST-1:0] obst_q;

    logic [N_OBST-1:0] acc_mask;
    logic [15:0]       acc_count;
    logic [N_OBST-1:0] hit_mask;
    logic [15:0]       hit_count;
    logic [15:0]       frame_cnt;

    logic              ctrl_en;
    logic [N_OBST-1:0] irq_mask;
    logic              irq_pend;

    logic [N_OBST-1:0] overlap;
    logic              sample;
    logic              frame_end;
    logic              irq_set;
    logic              irq_ack;
    logic              ctrl_wr;
    logic [31:0]       rd_mux;
    logic              unused_wdata;

    assign overlap   = obst_q & {N_OBST{dino_q}};
    // The HACTIVE bound guards against a blank_n that is misaligned with hcount.
    assign sample    = blank_q && !hc_q[0] && (hc_q < 11'(HACTIVE));
    assign frame_end = (vc_q == 10'(VACTIVE)) && (hc_q == 11'd0);

    assign irq_set = frame_end && ctrl_en && (state == S_ACTIVE)
                     && (|(acc_mask & irq_mask));
    assign irq_ack = chipselect && write && (address == 3'd3) && writedata[0];
    assign ctrl_wr = chipselect && write && (address == 3'd2);

    assign irq          = irq_pend;
    assign unused_wdata = ^writedata;

    // Input stage: one register on every renderer-side input.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hc_q    <= '0;
            vc_q    <= '0;
            blank_q <= 1'b0;
            dino_q  <= 1'b0;
            obst_q  <= '0;
        end else begin
            hc_q    <= hcount;
            vc_q    <= vcount;
            blank_q <= blank_n;
            dino_q  <= dino_opaque;
            obst_q  <= obst_opaque;
        end
    end

    // Frame-phase state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; dropping enable returns to IDLE from anywhere.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (ctrl_en) state_next = S_SYNC;
            S_SYNC:   if (frame_end) state_next = S_ACTIVE;
            S_ACTIVE: state_next = S_ACTIVE;
            default:  state_next = S_IDLE;
        endcase
        if (!ctrl_en) begin
            state_next = S_IDLE;
        end
    end

    // Per-frame accumulators; cleared at frame end and whenever not accumulating.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_mask  <= '0;
            acc_count <= '0;
        end else if (!ctrl_en || frame_end || (state != S_ACTIVE)) begin
            acc_mask  <= '0;
            acc_count <= '0;
        end else if (sample) begin
            acc_mask <= acc_mask | overlap;
            if ((|overlap) && (acc_count != 16'hFFFF)) begin
                acc_count <= acc_count + 16'd1;
            end
        end
    end

    // Publish at frame end; the frame that finishes SYNC is partial and is not published.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_mask  <= '0;
            hit_count <= '0;
            frame_cnt <= '0;
        end else if (frame_end) begin
            frame_cnt <= frame_cnt + 16'd1;
            if (state != S_SYNC) begin
                hit_mask  <= ctrl_en ? acc_mask  : '0;
                hit_count <= ctrl_en ? acc_count : 16'd0;
            end
        end
    end

    // CTRL register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_en  <= 1'b0;
            irq_mask <= '0;
        end else if (ctrl_wr) begin
            ctrl_en  <= writedata[0];
            irq_mask <= writedata[8 +: N_OBST];
        end
    end

    // Interrupt pending flag; a frame-end set beats a simultaneous acknowledge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_pend <= 1'b0;
        end else if (irq_set) begin
            irq_pend <= 1'b1;
        end else if (irq_ack) begin
            irq_pend <= 1'b0;
        end
    end

    // Read-data select for the register map.
    always_comb begin
        rd_mux = 32'd0;
        case (address)
            3'd0:    rd_mux = {hit_count, 8'd0, 8'(hit_mask)};
            3'd1:    rd_mux = {16'd0, frame_cnt};
            3'd2:    rd_mux = {16'd0, 8'(irq_mask), 7'd0, ctrl_en};
            3'd3:    rd_mux = {31'd0, irq_pend};
            default: rd_mux = 32'd0;
        endcase
    end

    // Registered read data, held until the next read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata <= '0;
        end else if (chipselect && read) begin
            readdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_sprite_collision_unit.sv
// Bench for sprite_collision_unit: directed pixel/frame stimulus, register
// reads checked by a scoreboard monitor one cycle after each read strobe.
module tb_sprite_collision_unit;

    localparam int N_OBST = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [10:0]       hcount;
    logic [9:0]        vcount;
    logic              blank_n;
    logic              dino_opaque;
    logic [N_OBST-1:0] obst_opaque;
    logic              chipselect;
    logic              read;
    logic              write;
    logic [2:0]        address;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic              irq;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          exp_frames = 0;
    logic [31:0] exp_q[$];
    string       name_q[$];
    logic [31:0] mon_exp;
    string       mon_name;

    sprite_collision_unit #(
        .N_OBST  (N_OBST),
        .VACTIVE (480),
        .HACTIVE (1280)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .hcount      (hcount),
        .vcount      (vcount),
        .blank_n     (blank_n),
        .dino_opaque (dino_opaque),
        .obst_opaque (obst_opaque),
        .chipselect  (chipselect),
        .read        (read),
        .write       (write),
        .address     (address),
        .writedata   (writedata),
        .readdata    (readdata),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Monitor: readdata is compared one cycle after each accepted read.
    initial begin
        forever begin
            @(posedge clk);
            if (reset === 1'b0 && chipselect === 1'b1 && read === 1'b1) begin
                @(negedge clk);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rd_unexpected: got 0x%08h with no expected value queued", readdata);
                end else begin
                    mon_exp  = exp_q.pop_front();
                    mon_name = name_q.pop_front();
                    check(mon_name, readdata, mon_exp);
                end
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_pix();
        vcount      = 10'd481;
        hcount      = 11'd0;
        blank_n     = 1'b0;
        dino_opaque = 1'b0;
        obst_opaque = '0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] e, input string nm);
        exp_q.push_back(e);
        name_q.push_back(nm);
        chipselect = 1'b1;
        read       = 1'b1;
        address    = a;
        tick();
        chipselect = 1'b0;
        read       = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write      = 1'b1;
        address    = a;
        writedata  = d;
        tick();
        chipselect = 1'b0;
        write      = 1'b0;
    endtask

    task automatic overlap_line(input int h0, input int ncyc, input logic [N_OBST-1:0] ob);
        for (int i = 0; i < ncyc; i++) begin
            vcount      = 10'd100;
            hcount      = 11'(h0 + i);
            blank_n     = 1'b1;
            dino_opaque = 1'b1;
            obst_opaque = ob;
            tick();
        end
        idle_pix();
    endtask

    // Drive vcount=480/hcount=0; optional ack or STATUS read lands in the frame-end cycle.
    task automatic frame_end_seq(input bit ack, input bit rd_status, input logic [31:0] st_exp);
        vcount      = 10'd480;
        hcount      = 11'd0;
        blank_n     = 1'b0;
        dino_opaque = 1'b0;
        obst_opaque = '0;
        tick();
        idle_pix();
        if (ack) begin
            chipselect = 1'b1;
            write      = 1'b1;
            address    = 3'd3;
            writedata  = 32'd1;
        end
        if (rd_status) begin
            exp_q.push_back(st_exp);
            name_q.push_back("fe_cycle_status_old");
            chipselect = 1'b1;
            read       = 1'b1;
            address    = 3'd0;
        end
        tick();
        chipselect = 1'b0;
        write      = 1'b0;
        read       = 1'b0;
        exp_frames++;
    endtask

    initial begin
        reset      = 1'b1;
        chipselect = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
        address    = 3'd0;
        writedata  = 32'd0;
        idle_pix();
        tick();
        tick();
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_readdata", readdata, 32'd0);
        reset = 1'b0;
        tick();

        // Build up en=1 with a pending irq, then reset mid-frame.
        wr(3'd2, 32'h0000_0101);
        tick();
        tick();
        frame_end_seq(0, 0, 32'd0);
        overlap_line(100, 20, 4'b0001);
        frame_end_seq(0, 0, 32'd0);
        check("pre_rst_irq", {31'd0, irq}, 32'd1);
        rd(3'd2, 32'h0000_0101, "pre_rst_ctrl");
        overlap_line(100, 6, 4'b0001);
        #3;
        reset = 1'b1;
        #1;
        check("async_rst_irq", {31'd0, irq}, 32'd0);
        check("async_rst_readdata", readdata, 32'd0);
        tick();
        reset = 1'b0;
        exp_frames = 0;
        tick();
        rd(3'd1, 32'd0, "frame_after_rst");
        rd(3'd2, 32'd0, "ctrl_after_rst");
        rd(3'd3, 32'd0, "irq_after_rst");
        rd(3'd0, 32'd0, "status_after_rst");

        // Enable; the first frame end only completes SYNC.
        wr(3'd2, 32'h0000_0101);
        tick();
        tick();
        overlap_line(100, 20, 4'b0001);
        frame_end_seq(0, 0, 32'd0);
        check("sync_irq", {31'd0, irq}, 32'd0);
        rd(3'd0, 32'd0, "sync_status");
        rd(3'd1, 32'(exp_frames), "sync_frame");

        for (int k = 0; k < 2; k++) begin
            overlap_line(100, 20, 4'b0001);
            frame_end_seq(0, 0, 32'd0);
            check("t2_irq", {31'd0, irq}, 32'd1);
            rd(3'd0, 32'h000A_0001, "t2_status");
            rd(3'd1, 32'(exp_frames), "t2_frame");
            wr(3'd3, 32'd1);
            check("t2_ack", {31'd0, irq}, 32'd0);
        end

        // Obstacle 2 only, masked out of the interrupt.
        overlap_line(300, 10, 4'b0100);
        frame_end_seq(0, 0, 32'd0);
        check("t3_irq", {31'd0, irq}, 32'd0);
        rd(3'd0, 32'h0005_0004, "t3_status");

        // Overlap during blanking is ignored.
        for (int i = 0; i < 20; i++) begin
            vcount      = 10'd100;
            hcount      = 11'(1280 + i);
            blank_n     = 1'b0;
            dino_opaque = 1'b1;
            obst_opaque = 4'b1111;
            tick();
        end
        idle_pix();
        frame_end_seq(0, 0, 32'd0);
        check("t4_irq", {31'd0, irq}, 32'd0);
        rd(3'd0, 32'd0, "t4_status");

        // 70000 overlapping samples saturate hit_count.
        vcount      = 10'd100;
        hcount      = 11'd200;
        blank_n     = 1'b1;
        dino_opaque = 1'b1;
        obst_opaque = 4'b0001;
        repeat (70000) tick();
        idle_pix();
        frame_end_seq(0, 0, 32'd0);
        rd(3'd0, 32'hFFFF_0001, "t5_saturate");
        check("t5_irq", {31'd0, irq}, 32'd1);

        // Quiet ack, then ack colliding with a setting frame end.
        wr(3'd3, 32'd1);
        check("t6_quiet_ack", {31'd0, irq}, 32'd0);
        overlap_line(100, 20, 4'b0001);
        frame_end_seq(1, 0, 32'd0);
        check("t6_set_wins", {31'd0, irq}, 32'd1);
        rd(3'd0, 32'h000A_0001, "t6_status");
        overlap_line(100, 8, 4'b0100);
        frame_end_seq(0, 1, 32'h000A_0001);
        tick();
        tick();
        check("t6_readdata_hold", readdata, 32'h000A_0001);
        rd(3'd0, 32'h0004_0004, "t6_new_status");
        check("t6_irq_still", {31'd0, irq}, 32'd1);
        wr(3'd3, 32'd1);
        check("t6_final_ack", {31'd0, irq}, 32'd0);

        // CTRL bit masking and unmapped addresses.
        wr(3'd2, 32'hFFFF_FFFF);
        rd(3'd2, 32'h0000_0F01, "ctrl_masked_bits");
        wr(3'd4, 32'hDEAD_BEEF);
        rd(3'd4, 32'd0, "addr4");
        rd(3'd7, 32'd0, "addr7");

        // Disabled: frame end publishes zeros and still counts frames.
        wr(3'd2, 32'd0);
        overlap_line(100, 20, 4'b0001);
        frame_end_seq(0, 0, 32'd0);
        check("en0_irq", {31'd0, irq}, 32'd0);
        rd(3'd0, 32'd0, "en0_status");
        rd(3'd1, 32'(exp_frames), "en0_frame");

        tick();
        tick();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
